// File: rtl/imageproc_cmd_master.sv
// imageproc_cmd_master: host-side initiator for the imageproc command interface.
// Buffers host commands in a small FIFO and issues them one at a time to
// imageproc when it is not busy, with an ack timeout and sticky error flags
// that halt issuing until software clears them.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   host_cmd/host_data         command + data to enqueue on host_push
//   host_push                  enqueue strobe
//   clear_err                  leave HALT, clear sticky flags
//   host_full, fifo_level      FIFO status
//   cmd, cmd_data, cmd_valid   request to imageproc
//   cmd_ack, busy, refresh, error   imageproc status inputs
//   err_flag, timeout, overflow     sticky flags
//   halted                     FSM is in HALT
//   issued_cnt                 acked commands (wrapping)
//   refresh_cnt                refresh pulses (saturating)
module imageproc_cmd_master #(
  parameter int unsigned CMD_W      = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CMD_W-1:0]                host_cmd,
  input  logic [DATA_W-1:0]               host_data,
  input  logic                            host_push,
  input  logic                            clear_err,
  output logic                            host_full,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [CMD_W-1:0]                cmd,
  output logic [DATA_W-1:0]               cmd_data,
  output logic                            cmd_valid,
  input  logic                            cmd_ack,
  input  logic                            busy,
  input  logic                            refresh,
  input  logic                            error,
  output logic                            err_flag,
  output logic                            timeout,
  output logic                            overflow,
  output logic                            halted,
  output logic [15:0]                     issued_cnt,
  output logic [15:0]                     refresh_cnt
);

  localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned ENT_W = CMD_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                full_q, full_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                err_q, err_d;
  logic                tmo_q, tmo_d;
  logic                ovf_q, ovf_d;
  logic                halted_q, halted_d;
  logic [15:0]         issued_q, issued_d;
  logic [15:0]         refresh_q, refresh_d;
  logic                push_ok;
  logic                pop;
  logic [ENT_W-1:0]    head;

  // A full FIFO refuses the push even if the FSM pops the same edge.
  assign push_ok = host_push && !full_q;
  assign head    = mem_q[rd_ptr_q];

  // Next-state and output logic for the issue FSM and status registers.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    to_cnt_d  = to_cnt_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    ovf_d     = ovf_q;
    issued_d  = issued_q;
    refresh_d = refresh_q;
    pop       = 1'b0;

    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (error) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else if ((level_q != '0) && !busy) begin
          pop      = 1'b1;
          cmd_d    = head[ENT_W-1:DATA_W];
          data_d   = head[DATA_W-1:0];
          valid_d  = 1'b1;
          to_cnt_d = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (error) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          if (cmd_ack) issued_d = issued_q + 16'd1;
          state_d = HALT;
        end else if (cmd_ack) begin
          valid_d  = 1'b0;
          issued_d = issued_q + 16'd1;
          state_d  = IDLE;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          // Unacked command is dropped; cmd_valid was high TIMEOUT cycles.
          valid_d = 1'b0;
          tmo_d   = 1'b1;
          state_d = HALT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      HALT: begin
        valid_d = 1'b0;
        if (error) begin
          err_d = 1'b1;
        end else if (clear_err) begin
          err_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    // A new overflow on the clearing edge still wins.
    if (host_push && full_q) begin
      ovf_d = 1'b1;
    end else if (clear_err) begin
      ovf_d = 1'b0;
    end

    if (refresh && (refresh_q != 16'hFFFF)) refresh_d = refresh_q + 16'd1;
  end

  // FIFO pointer and level bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop);
    full_d   = (level_d == LVL_W'(FIFO_DEPTH));
    halted_d = (state_d == HALT);
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {host_cmd, host_data};
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      cmd_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      to_cnt_q  <= '0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
      ovf_q     <= 1'b0;
      halted_q  <= 1'b0;
      issued_q  <= '0;
      refresh_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      full_q    <= full_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      to_cnt_q  <= to_cnt_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      ovf_q     <= ovf_d;
      halted_q  <= halted_d;
      issued_q  <= issued_d;
      refresh_q <= refresh_d;
    end
  end

  assign host_full   = full_q;
  assign fifo_level  = level_q;
  assign cmd         = cmd_q;
  assign cmd_data    = data_q;
  assign cmd_valid   = valid_q;
  assign err_flag    = err_q;
  assign timeout     = tmo_q;
  assign overflow    = ovf_q;
  assign halted      = halted_q;
  assign issued_cnt  = issued_q;
  assign refresh_cnt = refresh_q;

endmodule

// File: tb/tb_imageproc_cmd_master.sv
// tb_imageproc_cmd_master: self-checking bench for imageproc_cmd_master
// (TIMEOUT=8). Table vectors, directed corner sequences, and randomized
// traffic compared against a queue-based transaction model.
module tb_imageproc_cmd_master;

  localparam int TMO   = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  host_cmd;
  logic [7:0]  host_data;
  logic        host_push, clear_err, host_full;
  logic [2:0]  fifo_level;
  logic [3:0]  cmd;
  logic [7:0]  cmd_data;
  logic        cmd_valid, cmd_ack, busy, refresh, error;
  logic        err_flag, timeout, overflow, halted;
  logic [15:0] issued_cnt, refresh_cnt;

  imageproc_cmd_master #(.CMD_W(4), .DATA_W(8), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .host_cmd(host_cmd), .host_data(host_data),
    .host_push(host_push), .clear_err(clear_err), .host_full(host_full),
    .fifo_level(fifo_level), .cmd(cmd), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ack(cmd_ack), .busy(busy), .refresh(refresh), .error(error),
    .err_flag(err_flag), .timeout(timeout), .overflow(overflow), .halted(halted),
    .issued_cnt(issued_cnt), .refresh_cnt(refresh_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level model: pending commands, the one in flight, flags.
  logic [11:0] m_q[$];
  bit          m_busy_issue;   // a command is being offered
  bit          m_stopped;      // issuing halted
  int          m_age;          // cycles the current offer has waited
  int          m_cmd, m_data, m_iss, m_ref;
  bit          m_err, m_tmo, m_ovf;

  function automatic void model_reset();
    m_q.delete();
    m_busy_issue = 0; m_stopped = 0; m_age = 0;
    m_cmd = 0; m_data = 0; m_iss = 0; m_ref = 0;
    m_err = 0; m_tmo = 0; m_ovf = 0;
  endfunction

  function automatic void model_edge();
    bit was_full = (m_q.size() == DEPTH);
    if (host_push && was_full) m_ovf = 1;
    else if (clear_err) m_ovf = 0;
    if (refresh && m_ref < 65535) m_ref++;
    if (m_stopped) begin
      if (error) m_err = 1;
      else if (clear_err) begin m_err = 0; m_tmo = 0; m_stopped = 0; end
    end else if (m_busy_issue) begin
      if (error) begin
        m_busy_issue = 0; m_err = 1; m_stopped = 1;
        if (cmd_ack) m_iss = (m_iss + 1) % 65536;
      end else if (cmd_ack) begin
        m_busy_issue = 0; m_iss = (m_iss + 1) % 65536;
      end else if (m_age + 1 == TMO) begin
        m_busy_issue = 0; m_tmo = 1; m_stopped = 1;
      end else m_age++;
    end else begin
      if (error) begin m_err = 1; m_stopped = 1; end
      else if (m_q.size() > 0 && !busy) begin
        logic [11:0] e = m_q.pop_front();
        m_cmd = int'(e[11:8]); m_data = int'(e[7:0]);
        m_busy_issue = 1; m_age = 0;
      end
    end
    if (host_push && !was_full) m_q.push_back({host_cmd, host_data});
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic check_all();
    chk("cmd_valid",   32'(cmd_valid),   32'(m_busy_issue));
    chk("cmd",         32'(cmd),         32'(m_cmd));
    chk("cmd_data",    32'(cmd_data),    32'(m_data));
    chk("fifo_level",  32'(fifo_level),  32'(m_q.size()));
    chk("host_full",   32'(host_full),   32'(m_q.size() == DEPTH));
    chk("err_flag",    32'(err_flag),    32'(m_err));
    chk("timeout",     32'(timeout),     32'(m_tmo));
    chk("overflow",    32'(overflow),    32'(m_ovf));
    chk("halted",      32'(halted),      32'(m_stopped));
    chk("issued_cnt",  32'(issued_cnt),  32'(m_iss));
    chk("refresh_cnt", 32'(refresh_cnt), 32'(m_ref));
  endtask

  // One clock: model follows the edge, outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    host_push = 0; host_cmd = '0; host_data = '0; clear_err = 0;
    cmd_ack = 0; busy = 0; refresh = 0; error = 0;
  endtask

  typedef struct {
    int push, c, d, busy, ack, err, clr, rfr;
    int ev, ec, ed, el, ei, ee, eh, er;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int n_got, hi;
    int got[4];
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    tick(); tick();
    check_all();
    rst_n = 1'b1;

    // push  c    d    busy ack err clr rfr | valid cmd data lvl iss errf halt rcnt
    tbl[0]  = '{1, 3, 'hA5, 0, 0, 0, 0, 0,   0, 0, 'h00, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0,    0, 0, 0, 0, 0,   1, 3, 'hA5, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0,    0, 0, 0, 0, 1,   1, 3, 'hA5, 0, 0, 0, 0, 1};
    tbl[3]  = '{0, 0, 0,    0, 0, 0, 0, 0,   1, 3, 'hA5, 0, 0, 0, 0, 1};
    tbl[4]  = '{0, 0, 0,    0, 1, 0, 0, 0,   0, 3, 'hA5, 0, 1, 0, 0, 1};
    tbl[5]  = '{0, 0, 0,    0, 0, 0, 0, 0,   0, 3, 'hA5, 0, 1, 0, 0, 1};
    tbl[6]  = '{1, 5, 'h11, 0, 0, 0, 0, 0,   0, 3, 'hA5, 1, 1, 0, 0, 1};
    tbl[7]  = '{0, 0, 0,    0, 0, 0, 0, 0,   1, 5, 'h11, 0, 1, 0, 0, 1};
    tbl[8]  = '{0, 0, 0,    0, 1, 1, 0, 1,   0, 5, 'h11, 0, 2, 1, 1, 2};
    tbl[9]  = '{0, 0, 0,    0, 0, 1, 1, 0,   0, 5, 'h11, 0, 2, 1, 1, 2};
    tbl[10] = '{0, 0, 0,    0, 0, 0, 1, 0,   0, 5, 'h11, 0, 2, 0, 0, 2};
    tbl[11] = '{0, 0, 0,    0, 1, 0, 0, 0,   0, 5, 'h11, 0, 2, 0, 0, 2};

    for (int i = 0; i < 12; i++) begin
      host_push = 1'(tbl[i].push); host_cmd = 4'(tbl[i].c); host_data = 8'(tbl[i].d);
      busy = 1'(tbl[i].busy); cmd_ack = 1'(tbl[i].ack); error = 1'(tbl[i].err);
      clear_err = 1'(tbl[i].clr); refresh = 1'(tbl[i].rfr);
      tick();
      chk($sformatf("tbl%0d.valid", i),  32'(cmd_valid),   32'(tbl[i].ev));
      chk($sformatf("tbl%0d.cmd", i),    32'(cmd),         32'(tbl[i].ec));
      chk($sformatf("tbl%0d.data", i),   32'(cmd_data),    32'(tbl[i].ed));
      chk($sformatf("tbl%0d.level", i),  32'(fifo_level),  32'(tbl[i].el));
      chk($sformatf("tbl%0d.issued", i), 32'(issued_cnt),  32'(tbl[i].ei));
      chk($sformatf("tbl%0d.err", i),    32'(err_flag),    32'(tbl[i].ee));
      chk($sformatf("tbl%0d.halted", i), 32'(halted),      32'(tbl[i].eh));
      chk($sformatf("tbl%0d.refresh", i),32'(refresh_cnt), 32'(tbl[i].er));
    end
    idle_inputs();

    // Busy gating, fill to full, overflow, then in-order back-to-back issue.
    busy = 1;
    for (int i = 0; i < 4; i++) begin
      host_push = 1; host_cmd = 4'(8 + i); host_data = 8'(8'h40 + i);
      tick(); check_all();
    end
    host_push = 0;
    for (int i = 0; i < 6; i++) begin tick(); check_all(); end
    chk("busy_full", 32'(host_full), 32'd1);
    chk("busy_no_valid", 32'(cmd_valid), 32'd0);
    host_push = 1; host_cmd = 4'hF; host_data = 8'hFF;
    tick(); check_all();
    chk("overflow_set", 32'(overflow), 32'd1);
    host_push = 0; busy = 0;
    n_got = 0;
    for (int c = 0; c < 40 && n_got < 4; c++) begin
      tick(); check_all();
      if (cmd_valid) begin
        got[n_got] = int'(cmd_data); n_got++;
        cmd_ack = 1; tick(); cmd_ack = 0; check_all();
        chk("gap_after_ack", 32'(cmd_valid), 32'd0);
      end
    end
    chk("b2b_count", 32'(n_got), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("b2b_order%0d", i), 32'(got[i]), 32'(8'h40 + i));
    chk("b2b_issued", 32'(issued_cnt), 32'd6);
    chk("b2b_level", 32'(fifo_level), 32'd0);

    // Ack timeout: valid high exactly TMO cycles, then halted until cleared.
    clear_err = 1; tick(); clear_err = 0; check_all();
    chk("ovf_cleared", 32'(overflow), 32'd0);
    host_push = 1; host_cmd = 4'h7; host_data = 8'h77; tick();
    host_cmd = 4'h9; host_data = 8'h99; tick(); host_push = 0; check_all();
    hi = int'(cmd_valid);
    for (int c = 0; c < 40 && !halted; c++) begin
      tick(); check_all();
      if (cmd_valid) hi++;
    end
    chk("tmo_high_cycles", 32'(hi), 32'(TMO));
    chk("tmo_flag", 32'(timeout), 32'd1);
    chk("tmo_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 5; i++) begin tick(); check_all(); end
    chk("tmo_held_level", 32'(fifo_level), 32'd1);
    clear_err = 1; tick(); clear_err = 0; check_all();
    hi = 0;
    for (int c = 0; c < 10 && !cmd_valid; c++) begin tick(); check_all(); end
    chk("tmo_resume_valid", 32'(cmd_valid), 32'd1);
    chk("tmo_resume_data", 32'(cmd_data), 32'h99);
    cmd_ack = 1; tick(); cmd_ack = 0; check_all();

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      host_push = ($urandom_range(99) < 40); host_cmd = 4'($urandom); host_data = 8'($urandom);
      busy = ($urandom_range(99) < 30); cmd_ack = ($urandom_range(99) < 30);
      error = ($urandom_range(99) < 3); clear_err = ($urandom_range(99) < 10);
      refresh = ($urandom_range(99) < 50);
      tick(); check_all();
    end
    idle_inputs();

    // Asynchronous reset while a command is in flight.
    clear_err = 1; tick(); clear_err = 0;
    tick(); tick();
    host_push = 1; host_cmd = 4'h2; host_data = 8'h22; tick(); host_push = 0;
    tick(); check_all();
    chk("rst_pre_valid", 32'(cmd_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 model_reset(); check_all();
    tick(); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); check_all(); end
    chk("rst_no_issue", 32'(cmd_valid), 32'd0);

    // Refresh counter saturation.
    refresh = 1;
    for (int i = 0; i < 65534; i++) tick();
    chk("refresh_fffe", 32'(refresh_cnt), 32'hFFFE);
    for (int i = 0; i < 6; i++) tick();
    chk("refresh_sat", 32'(refresh_cnt), 32'hFFFF);
    check_all();
    refresh = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
